// File: rtl/ramtest_ctrl_if.sv
// Memory-controller user port 0: command, write-data and read-data FIFO signals.
// master = bridge side (issues commands, pushes writes, pops reads); slave = controller side.
interface ramtest_ctrl_if #(
    parameter int ADDR_WIDTH = 30
);
    logic                  p0_cmd_en;
    logic [2:0]            p0_cmd_instr;
    logic [5:0]            p0_cmd_bl;
    logic [ADDR_WIDTH-1:0] p0_cmd_byte_addr;
    logic                  p0_cmd_full;

    logic                  p0_wr_en;
    logic [31:0]           p0_wr_data;
    logic [3:0]            p0_wr_mask;
    logic                  p0_wr_full;
    logic [6:0]            p0_wr_count;

    logic                  p0_rd_en;
    logic [31:0]           p0_rd_data;
    logic                  p0_rd_empty;
    logic [6:0]            p0_rd_count;

    modport master (
        output p0_cmd_en, p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr,
        input  p0_cmd_full,
        output p0_wr_en, p0_wr_data, p0_wr_mask,
        input  p0_wr_full, p0_wr_count,
        output p0_rd_en,
        input  p0_rd_data, p0_rd_empty, p0_rd_count
    );

    modport slave (
        input  p0_cmd_en, p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr,
        output p0_cmd_full,
        input  p0_wr_en, p0_wr_data, p0_wr_mask,
        output p0_wr_full, p0_wr_count,
        input  p0_rd_en,
        output p0_rd_data, p0_rd_empty, p0_rd_count
    );
endinterface

// File: rtl/ramtest_ctrl.sv
// Host pipe <-> memory-controller port 0 bridge: packs 16-bit pipe words into 32-bit
// FIFO words, issues fixed-length write/read bursts at a wrapping linear address.
module ramtest_ctrl #(
    parameter int BURST_LEN  = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_WIDTH = 30,
    parameter int MEM_BYTES  = 134217728
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [15:0] ep_wirein,
    input  logic        pipe_in_write,
    input  logic [15:0] pipe_in_data,
    output logic        pipe_in_ready,
    input  logic        pipe_out_read,
    output logic [15:0] pipe_out_data,
    output logic        pipe_out_ready,
    input  logic        calib_done,
    ramtest_ctrl_if.master p0,
    output logic [3:0]  led,
    output logic        overflow
);
    localparam int PEND_W = $clog2(FIFO_DEPTH + BURST_LEN + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(4 * BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(MEM_BYTES - 4 * BURST_LEN);
    localparam logic [6:0]            CNT_BURST  = 7'(BURST_LEN);
    localparam logic [6:0]            CNT_ROOM   = 7'(FIFO_DEPTH - BURST_LEN);
    localparam logic [PEND_W-1:0]     PEND_BURST = PEND_W'(BURST_LEN);
    localparam logic [PEND_W-1:0]     PEND_LIMIT = PEND_W'(FIFO_DEPTH - BURST_LEN);
    localparam logic [PEND_W-1:0]     PEND_ONE   = PEND_W'(1);

    logic soft_rst, write_mode, read_mode, unused_wirein;
    logic pop, rd_en, issue_wr, issue_rd;

    logic                  in_sel_reg, in_sel_next;
    logic [15:0]           low_half_reg, low_half_next;
    logic                  overflow_reg, overflow_next;
    logic                  wr_en_reg, wr_en_next;
    logic [31:0]           wr_data_reg, wr_data_next;
    logic                  out_sel_reg, out_sel_next;
    logic                  cmd_en_reg, cmd_en_next;
    logic [2:0]            cmd_instr_reg, cmd_instr_next;
    logic [ADDR_WIDTH-1:0] cmd_addr_reg, cmd_addr_next;
    logic [ADDR_WIDTH-1:0] wr_addr_reg, wr_addr_next;
    logic [ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;
    logic [PEND_W-1:0]     pending_reg, pending_next;
    logic                  in_ready_reg, in_ready_next;
    logic                  out_ready_reg, out_ready_next;

    function automatic logic [ADDR_WIDTH-1:0] advance(input logic [ADDR_WIDTH-1:0] a);
        return (a >= ADDR_LAST) ? '0 : a + ADDR_STEP;
    endfunction

    assign soft_rst      = ep_wirein[2];
    assign write_mode    = ep_wirein[1] & ~ep_wirein[0] & ~ep_wirein[2];
    assign read_mode     = ep_wirein[0] & ~ep_wirein[1] & ~ep_wirein[2];
    assign unused_wirein = ^ep_wirein[15:3];

    assign pop   = pipe_out_read & ~p0.p0_rd_empty & ~soft_rst;
    assign rd_en = pop & out_sel_reg;

    // cmd_en_reg high means wr_count has not yet reflected the last write burst
    assign issue_wr = write_mode & calib_done & ~p0.p0_cmd_full
                    & (p0.p0_wr_count >= CNT_BURST) & ~cmd_en_reg;
    assign issue_rd = read_mode & calib_done & ~p0.p0_cmd_full & (pending_reg <= PEND_LIMIT);

    always_comb begin
        in_sel_next    = in_sel_reg;
        low_half_next  = low_half_reg;
        overflow_next  = overflow_reg;
        wr_en_next     = 1'b0;
        wr_data_next   = wr_data_reg;
        out_sel_next   = out_sel_reg ^ pop;
        cmd_en_next    = 1'b0;
        cmd_instr_next = cmd_instr_reg;
        cmd_addr_next  = cmd_addr_reg;
        wr_addr_next   = wr_addr_reg;
        rd_addr_next   = rd_addr_reg;
        in_ready_next  = write_mode & calib_done & (p0.p0_wr_count <= CNT_ROOM);
        out_ready_next = read_mode & (p0.p0_rd_count >= CNT_BURST);
        // pops of data left over from before a reset must not wrap the counter
        pending_next   = pending_reg + (issue_rd ? PEND_BURST : '0)
                       - ((rd_en && (pending_reg != '0 || issue_rd)) ? PEND_ONE : '0);

        if (pipe_in_write) begin
            in_sel_next = ~in_sel_reg;
            if (!in_sel_reg) begin
                low_half_next = pipe_in_data;
            end else if (p0.p0_wr_full) begin
                overflow_next = 1'b1;
            end else begin
                wr_en_next   = 1'b1;
                wr_data_next = {pipe_in_data, low_half_reg};
            end
        end

        if (issue_wr) begin
            cmd_en_next    = 1'b1;
            cmd_instr_next = 3'b000;
            cmd_addr_next  = wr_addr_reg;
            wr_addr_next   = advance(wr_addr_reg);
        end else if (issue_rd) begin
            cmd_en_next    = 1'b1;
            cmd_instr_next = 3'b001;
            cmd_addr_next  = rd_addr_reg;
            rd_addr_next   = advance(rd_addr_reg);
        end

        if (soft_rst) begin
            in_sel_next    = 1'b0;
            low_half_next  = '0;
            overflow_next  = 1'b0;
            wr_en_next     = 1'b0;
            out_sel_next   = 1'b0;
            cmd_en_next    = 1'b0;
            wr_addr_next   = '0;
            rd_addr_next   = '0;
            pending_next   = '0;
            in_ready_next  = 1'b0;
            out_ready_next = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            in_sel_reg    <= 1'b0;
            low_half_reg  <= '0;
            overflow_reg  <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_data_reg   <= '0;
            out_sel_reg   <= 1'b0;
            cmd_en_reg    <= 1'b0;
            cmd_instr_reg <= 3'b000;
            cmd_addr_reg  <= '0;
            wr_addr_reg   <= '0;
            rd_addr_reg   <= '0;
            pending_reg   <= '0;
            in_ready_reg  <= 1'b0;
            out_ready_reg <= 1'b0;
        end else begin
            in_sel_reg    <= in_sel_next;
            low_half_reg  <= low_half_next;
            overflow_reg  <= overflow_next;
            wr_en_reg     <= wr_en_next;
            wr_data_reg   <= wr_data_next;
            out_sel_reg   <= out_sel_next;
            cmd_en_reg    <= cmd_en_next;
            cmd_instr_reg <= cmd_instr_next;
            cmd_addr_reg  <= cmd_addr_next;
            wr_addr_reg   <= wr_addr_next;
            rd_addr_reg   <= rd_addr_next;
            pending_reg   <= pending_next;
            in_ready_reg  <= in_ready_next;
            out_ready_reg <= out_ready_next;
        end
    end

    assign p0.p0_cmd_en        = cmd_en_reg;
    assign p0.p0_cmd_instr     = cmd_instr_reg;
    assign p0.p0_cmd_bl        = 6'(BURST_LEN - 1);
    assign p0.p0_cmd_byte_addr = cmd_addr_reg;
    assign p0.p0_wr_en         = wr_en_reg;
    assign p0.p0_wr_data       = wr_data_reg;
    assign p0.p0_wr_mask       = 4'b0000;
    assign p0.p0_rd_en         = rd_en;

    assign pipe_out_data  = out_sel_reg ? p0.p0_rd_data[31:16] : p0.p0_rd_data[15:0];
    assign pipe_in_ready  = in_ready_reg;
    assign pipe_out_ready = out_ready_reg;
    assign overflow       = overflow_reg;
    assign led            = {~overflow_reg, ~read_mode, ~write_mode, ~calib_done};
endmodule

// File: tb/tb_ramtest_ctrl.sv
// Directed bench for ramtest_ctrl: FIFO/memory model on port 0, host-level scoreboard
// checked every cycle, plus literal expectations for addresses, data and status.
module tb_ramtest_ctrl;
    localparam int BL   = 32;
    localparam int FD   = 64;
    localparam int AW   = 30;
    localparam int MEMB = 1024;   // small memory so the address wrap is reachable quickly

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ep_wirein = 16'h0000;
    logic        pipe_in_write = 1'b0;
    logic [15:0] pipe_in_data = 16'h0000;
    logic        pipe_out_read = 1'b0;
    logic        calib_done = 1'b0;
    logic        force_full = 1'b0;
    logic        wfull_q = 1'b0;
    wire         pipe_in_ready, pipe_out_ready, overflow;
    wire  [15:0] pipe_out_data;
    wire  [3:0]  led;

    always #5 sys_clk = ~sys_clk;

    ramtest_ctrl_if #(.ADDR_WIDTH(AW)) p0_bus ();

    ramtest_ctrl #(.BURST_LEN(BL), .FIFO_DEPTH(FD), .ADDR_WIDTH(AW), .MEM_BYTES(MEMB)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .ep_wirein(ep_wirein),
        .pipe_in_write(pipe_in_write), .pipe_in_data(pipe_in_data), .pipe_in_ready(pipe_in_ready),
        .pipe_out_read(pipe_out_read), .pipe_out_data(pipe_out_data), .pipe_out_ready(pipe_out_ready),
        .calib_done(calib_done), .p0(p0_bus), .led(led), .overflow(overflow)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Controller-side FIFOs and memory
    logic [31:0] wq[$];
    logic [31:0] rq[$];
    logic [31:0] mem[int];
    logic [31:0] dropped;
    int          slave_base;

    assign p0_bus.p0_cmd_full = 1'b0;
    assign p0_bus.p0_wr_full  = force_full | wfull_q;

    always @(posedge sys_clk) begin
        if (!rst_n) begin
            wq.delete();
            rq.delete();
            mem.delete();
            wfull_q               <= 1'b0;
            p0_bus.p0_wr_count    <= 7'd0;
            p0_bus.p0_rd_count    <= 7'd0;
            p0_bus.p0_rd_empty    <= 1'b1;
            p0_bus.p0_rd_data     <= 32'h0;
        end else begin
            if (p0_bus.p0_cmd_en) begin
                slave_base = int'(p0_bus.p0_cmd_byte_addr >> 2);
                for (int i = 0; i < BL; i++) begin
                    if (p0_bus.p0_cmd_instr == 3'b000) begin
                        if (wq.size() > 0) mem[slave_base + i] = wq.pop_front();
                    end else if (p0_bus.p0_cmd_instr == 3'b001) begin
                        rq.push_back(mem.exists(slave_base + i) ? mem[slave_base + i] : 32'h0);
                    end
                end
            end
            if (p0_bus.p0_wr_en && !p0_bus.p0_wr_full) wq.push_back(p0_bus.p0_wr_data);
            if (p0_bus.p0_rd_en && rq.size() > 0) dropped = rq.pop_front();
            wfull_q            <= (wq.size() >= FD);
            p0_bus.p0_wr_count <= 7'(wq.size());
            p0_bus.p0_rd_count <= 7'(rq.size());
            p0_bus.p0_rd_empty <= (rq.size() == 0);
            p0_bus.p0_rd_data  <= (rq.size() > 0) ? rq[0] : 32'h0;
        end
    end

    // Host-level model state
    logic              par = 1'b0;
    logic [15:0]       lowh = 16'h0;
    logic [31:0]       exp_wd[$];
    logic              ovf_exp = 1'b0;
    int                nwr = 0;
    int                nrd = 0;
    logic [AW-1:0]     wr_log[$];
    logic              prev_valid = 1'b0;
    logic              prev_wm = 1'b0, prev_rm = 1'b0, prev_cal = 1'b0;
    logic [6:0]        prev_wc = 7'd0, prev_rc = 7'd0;
    logic              wm, rm;
    logic [15:0]       gold16 [0:511];

    always @(negedge sys_clk) begin
        if (!rst_n) begin
            par = 1'b0; ovf_exp = 1'b0; exp_wd.delete(); nwr = 0; nrd = 0; prev_valid = 1'b0;
        end else begin
            wm = ep_wirein[1] & ~ep_wirein[0] & ~ep_wirein[2];
            rm = ep_wirein[0] & ~ep_wirein[1] & ~ep_wirein[2];
            check("led", 64'(led), 64'({~ovf_exp, ~rm, ~wm, ~calib_done}));
            check("overflow", 64'(overflow), 64'(ovf_exp));
            if (prev_valid) begin
                check("pipe_in_ready", 64'(pipe_in_ready),
                      64'(prev_wm & prev_cal & (int'(prev_wc) <= FD - BL)));
                check("pipe_out_ready", 64'(pipe_out_ready), 64'(prev_rm & (int'(prev_rc) >= BL)));
            end
            if (p0_bus.p0_rd_en)
                check("rd_en_legal", 64'({pipe_out_read, p0_bus.p0_rd_empty}), 64'(2'b10));
            if (p0_bus.p0_wr_en) begin
                check("wr_mask", 64'(p0_bus.p0_wr_mask), 64'(0));
                if (exp_wd.size() == 0) check("wr_en_unexpected", 64'(1), 64'(0));
                else check("wr_data", 64'(p0_bus.p0_wr_data), 64'(exp_wd.pop_front()));
            end
            if (p0_bus.p0_cmd_en) begin
                check("cmd_bl", 64'(p0_bus.p0_cmd_bl), 64'(BL - 1));
                check("cmd_calib", 64'(calib_done), 64'(1));
                if (p0_bus.p0_cmd_instr == 3'b000) begin
                    check("wr_cmd_addr", 64'(p0_bus.p0_cmd_byte_addr), 64'((nwr * 4 * BL) % MEMB));
                    check("wr_cmd_data_avail", 64'(wq.size() >= BL), 64'(1));
                    wr_log.push_back(p0_bus.p0_cmd_byte_addr);
                    nwr++;
                end else if (p0_bus.p0_cmd_instr == 3'b001) begin
                    check("rd_cmd_addr", 64'(p0_bus.p0_cmd_byte_addr), 64'((nrd * 4 * BL) % MEMB));
                    nrd++;
                end else begin
                    check("cmd_instr", 64'(p0_bus.p0_cmd_instr), 64'(0));
                end
            end
            check("rd_fifo_bound", 64'(rq.size() <= FD), 64'(1));

            if (ep_wirein[2]) begin
                par = 1'b0; ovf_exp = 1'b0; exp_wd.delete(); nwr = 0; nrd = 0;
            end else if (pipe_in_write) begin
                if (!par) lowh = pipe_in_data;
                else if (p0_bus.p0_wr_full) ovf_exp = 1'b1;
                else exp_wd.push_back({pipe_in_data, lowh});
                par = ~par;
            end
            prev_wm = wm; prev_rm = rm; prev_cal = calib_done;
            prev_wc = p0_bus.p0_wr_count; prev_rc = p0_bus.p0_rd_count;
            prev_valid = 1'b1;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic write_block(input int b);
        int n;
        n = 0;
        while (!pipe_in_ready && n < 500) begin tick(); n++; end
        check("pipe_in_ready_wait", 64'(pipe_in_ready), 64'(1));
        for (int i = 0; i < 2 * BL; i++) begin
            pipe_in_write = 1'b1;
            pipe_in_data  = 16'h1000 + 16'(b * 2 * BL + i);
            gold16[(b % 8) * 2 * BL + i] = pipe_in_data;
            tick();
        end
        pipe_in_write = 1'b0;
        repeat (3) tick();
    endtask

    task automatic read_block(input int b);
        int n;
        n = 0;
        while (!pipe_out_ready && n < 500) begin tick(); n++; end
        check("pipe_out_ready_wait", 64'(pipe_out_ready), 64'(1));
        for (int i = 0; i < 2 * BL; i++) begin
            pipe_out_read = 1'b1;
            @(negedge sys_clk);
            check("pipe_out_data", 64'(pipe_out_data), 64'(gold16[b * 2 * BL + i]));
            check("rd_en_on_odd_word", 64'(p0_bus.p0_rd_en), 64'(i % 2));
            tick();
        end
        pipe_out_read = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1 rst_n = 1'b1;
        ep_wirein = 16'h0004; tick(); tick();
        ep_wirein = 16'h0000; tick(); tick();
        @(negedge sys_clk);
        check("reset_led", 64'(led), 64'(4'b1111));
        check("reset_overflow", 64'(overflow), 64'(0));
        check("reset_strobes", 64'({p0_bus.p0_cmd_en, p0_bus.p0_wr_en, p0_bus.p0_rd_en}), 64'(0));
        check("reset_ready", 64'({pipe_in_ready, pipe_out_ready}), 64'(0));

        // read attempt on an empty FIFO must neither pop nor advance the selector
        tick();
        pipe_out_read = 1'b1;
        @(negedge sys_clk);
        check("rd_en_on_empty", 64'(p0_bus.p0_rd_en), 64'(0));
        tick();
        pipe_out_read = 1'b0;
        calib_done = 1'b1;
        tick();
        @(negedge sys_clk);
        check("calib_led", 64'(led), 64'(4'b1110));

        // write 512 host words
        tick();
        ep_wirein = 16'h0002;
        for (int b = 0; b < 8; b++) write_block(b);
        for (int n = 0; n < 500 && nwr < 8; n++) tick();
        check("write_cmd_count", 64'(nwr), 64'(8));
        tick(); tick();
        check("wr_addr_1", 64'(wr_log[1]), 64'(30'h080));
        check("wr_addr_7", 64'(wr_log[7]), 64'(30'h380));
        check("mem_word_0", 64'(mem.exists(0) ? mem[0] : 32'hDEADDEAD), 64'(32'h1001_1000));
        check("mem_word_255", 64'(mem.exists(255) ? mem[255] : 32'hDEADDEAD), 64'(32'h11FF_11FE));
        for (int k = 0; k < 256; k++)
            check("mem_contents", 64'(mem.exists(k) ? mem[k] : 32'hDEADDEAD),
                  64'({gold16[2 * k + 1], gold16[2 * k]}));

        // read back 512 host words
        ep_wirein = 16'h0001;
        for (int b = 0; b < 8; b++) read_block(b);

        // host stalls: outstanding reads must stop at two bursts
        repeat (100) tick();
        @(negedge sys_clk);
        check("rd_fifo_level_stalled", 64'(rq.size()), 64'(64));
        check("read_cmd_count", 64'(nrd), 64'(10));
        check("pipe_out_ready_stalled", 64'(pipe_out_ready), 64'(1));

        // ninth write wraps to address 0
        tick();
        ep_wirein = 16'h0002;
        write_block(8);
        for (int n = 0; n < 500 && nwr < 9; n++) tick();
        check("write_cmd_count_wrap", 64'(nwr), 64'(9));
        tick(); tick();
        check("wr_addr_wrap", 64'(wr_log[8]), 64'(30'h000));
        check("mem_word_0_wrap", 64'(mem.exists(0) ? mem[0] : 32'hDEADDEAD), 64'(32'h1201_1200));

        // write-FIFO full on the second word of a pair
        pipe_in_write = 1'b1; pipe_in_data = 16'hBEEF; tick();
        force_full = 1'b1;    pipe_in_data = 16'hDEAD; tick();
        pipe_in_write = 1'b0; force_full = 1'b0;
        tick(); tick();
        @(negedge sys_clk);
        check("overflow_set", 64'(overflow), 64'(1));
        check("overflow_led", 64'(led[3]), 64'(0));
        check("dropped_word", 64'(wq.size()), 64'(0));
        repeat (5) tick();
        check("overflow_sticky", 64'(overflow), 64'(1));
        ep_wirein = 16'h0004; tick(); tick();
        ep_wirein = 16'h0000; tick();
        @(negedge sys_clk);
        check("overflow_cleared", 64'(overflow), 64'(0));
        check("final_led", 64'(led), 64'(4'b1110));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ramtest_ctrl.md
Name: ramtest_ctrl

Overview:
- Host-to-memory bridge for the RAM tester application.
- Accepts 16-bit host pipe-in words and packs them into 32-bit words for a memory-controller user port (command, write-data and read-data FIFOs).
- Issues fixed-length write/read bursts at a linearly advancing address, and unpacks read data back to 16-bit pipe-out words.
- Mode is selected by a host wire-in word; the block sits between the host interface endpoints and the memory controller port 0.

Parameters:
- BURST_LEN, 32, 32-bit words per memory command (cmd_bl = BURST_LEN-1).
- FIFO_DEPTH, 64, depth in 32-bit words of the controller write and read data FIFOs.
- ADDR_WIDTH, 30, byte-address width of the command port.
- MEM_BYTES, 134217728, memory size in bytes; address wraps to 0 at this value.

Ports:
- sys_clk, in, 1, single clock for all logic.
- rst_n, in, 1, asynchronous active-low reset.
- ep_wirein, in, 16, host control word: bit0 read mode, bit1 write mode, bit2 soft reset.
- pipe_in_write, in, 1, strobe: pipe_in_data is valid this cycle.
- pipe_in_data, in, 16, host write data.
- pipe_in_ready, out, 1, one block (2*BURST_LEN 16-bit words) may be written.
- pipe_out_read, in, 1, strobe: host consumes pipe_out_data this cycle.
- pipe_out_data, out, 16, host read data.
- pipe_out_ready, out, 1, one block is available to read.
- calib_done, in, 1, memory controller calibration complete.
- p0_cmd_en, out, 1, command strobe.
- p0_cmd_instr, out, 3, 000 write, 001 read.
- p0_cmd_bl, out, 6, burst length minus one.
- p0_cmd_byte_addr, out, ADDR_WIDTH, command byte address.
- p0_cmd_full, in, 1, command FIFO full.
- p0_wr_en, out, 1, write-data push.
- p0_wr_data, out, 32, write-data word.
- p0_wr_mask, out, 4, byte mask; always 0.
- p0_wr_full, in, 1, write-data FIFO full.
- p0_wr_count, in, 7, words in the write-data FIFO.
- p0_rd_en, out, 1, read-data pop.
- p0_rd_data, in, 32, read-data word.
- p0_rd_empty, in, 1, read-data FIFO empty.
- p0_rd_count, in, 7, words in the read-data FIFO.
- led, out, 4, active-low status: {~overflow, ~read_mode, ~write_mode, ~calib_done}.
- overflow, out, 1, sticky: pipe-in write arrived while p0_wr_full was high.

Behaviour:
- Reset (rst_n low, or ep_wirein[2]=1 synchronously):
  - clears wr_addr, rd_addr, pending, both half-word selectors, overflow and latched low half;
  - all strobes low; ready outputs low.
- Modes:
  - write_mode = bit1 & ~bit0 & ~bit2.
  - read_mode = bit0 & ~bit1 & ~bit2.
  - Both bits set means idle. No commands are issued unless calib_done=1.
- Pipe-in packing:
  - First word of each pair is latched as the low half.
  - The second word asserts p0_wr_en for one cycle with p0_wr_data = {second, first}.
  - The selector toggles on every pipe_in_write regardless of mode.
  - If p0_wr_full=1 at the push, the word is dropped and overflow sets.
- Write commands:
  - Issued when write_mode, p0_cmd_full=0 and p0_wr_count >= BURST_LEN.
  - The command must not be re-issued until p0_wr_count has been observed one cycle after the previous p0_cmd_en (one-cycle holdoff).
  - Fields: p0_cmd_en=1, instr 000, addr=wr_addr; then wr_addr += 4*BURST_LEN, modulo MEM_BYTES.
- Read commands:
  - Issued when read_mode, p0_cmd_full=0 and pending + BURST_LEN <= FIFO_DEPTH.
  - Fields: instr 001, addr=rd_addr; then rd_addr += 4*BURST_LEN, wrap at MEM_BYTES.
  - pending += BURST_LEN on each read command and -= 1 on each p0_rd_en; a same-cycle increment and decrement net out.
- Pipe-out unpacking:
  - pipe_out_data is combinational: p0_rd_data[15:0] when selector=0, [31:16] when selector=1.
  - pipe_out_read toggles the selector; on selector=1 it also asserts p0_rd_en combinationally in that cycle.
  - pipe_out_read while p0_rd_empty=1 is ignored: no toggle, no pop.
- Ready flags (registered, 1-cycle latency):
  - pipe_in_ready = write_mode & calib_done & (p0_wr_count <= FIFO_DEPTH - BURST_LEN).
  - pipe_out_ready = read_mode & (p0_rd_count >= BURST_LEN).
- Addresses are always 4*BURST_LEN aligned; p0_cmd_bl and p0_wr_mask are constant.
- Mode change mid-transfer does not clear addresses; only a reset does.

Test Plan:
- Reset, pulse ep_wirein=0x0004 then 0x0000 -> all strobes 0, led=4'b1111 until calib_done, then led=4'b1110; overflow=0.
- Write mode (0x0002), calib_done=1, write 512 words of random data -> 8 write commands at addresses 0x000,0x080,…,0x380, each with bl=31, instr=000, wr_data pairs little-endian.
- Switch to 0x0001 with a memory model -> read commands at 0x000 upward; reading 512 pipe-out words returns the identical sequence; zero mismatches.
- Hold host reads off in read mode -> no more than FIFO_DEPTH/BURST_LEN=2 read commands outstanding; pipe_out_ready=1 once rd_count>=32.
- Force p0_wr_full=1 during a second pipe-in word -> word dropped, overflow=1, led[3]=0 until reset.
- Set wr_addr near MEM_BYTES-128, issue one write -> next command address is 0.
